// File: rtl/prog_loader.sv
// Byte-stream program loader: receives framed images over a valid/ready
// byte port and writes them into CPU RAM while holding the CPU off the bus.
module prog_loader #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_we,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_HI,
        S_ADDR_LO,
        S_LEN,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_DONE
    } state_t;

    state_t      state;
    logic [7:0]  sum;
    logic [7:0]  sum_next;
    logic [7:0]  addr_hi;
    logic [8:0]  remaining;
    logic        xfer;

    // A byte moves only when the source offers it and we advertised ready.
    always_comb begin
        xfer     = rx_valid && rx_ready;
        sum_next = sum + rx_data;
    end

    // Frame parser, RAM write sequencer and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            sum       <= 8'h00;
            addr_hi   <= 8'h00;
            remaining <= 9'd0;
            rx_ready  <= 1'b0;
            mem_addr  <= '0;
            mem_data  <= 8'h00;
            mem_we    <= 1'b0;
            cpu_hold  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            if (state != S_IDLE && !enable) begin
                // Losing enable mid-frame abandons the frame and flags it.
                state    <= S_IDLE;
                err      <= 1'b1;
                cpu_hold <= 1'b0;
                busy     <= 1'b0;
                rx_ready <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        rx_ready <= enable;
                        if (xfer && enable && rx_data == 8'hA5) begin
                            state    <= S_ADDR_HI;
                            cpu_hold <= 1'b1;
                            busy     <= 1'b1;
                            err      <= 1'b0;
                            sum      <= 8'h00;
                        end
                    end
                    S_ADDR_HI: begin
                        if (xfer) begin
                            addr_hi <= rx_data;
                            sum     <= sum_next;
                            state   <= S_ADDR_LO;
                        end
                    end
                    S_ADDR_LO: begin
                        if (xfer) begin
                            mem_addr <= ADDR_W'({addr_hi, rx_data});
                            sum      <= sum_next;
                            state    <= S_LEN;
                        end
                    end
                    S_LEN: begin
                        if (xfer) begin
                            remaining <= (rx_data == 8'h00) ? 9'd256
                                                            : {1'b0, rx_data};
                            sum       <= sum_next;
                            state     <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (xfer) begin
                            mem_data <= rx_data;
                            sum      <= sum_next;
                            mem_we   <= 1'b1;
                            rx_ready <= 1'b0;
                            state    <= S_WRITE;
                        end
                    end
                    S_WRITE: begin
                        mem_addr  <= mem_addr + ADDR_W'(1);
                        remaining <= remaining - 9'd1;
                        rx_ready  <= 1'b1;
                        state     <= (remaining == 9'd1) ? S_CSUM : S_DATA;
                    end
                    S_CSUM: begin
                        if (xfer) begin
                            if (sum_next == 8'h00) begin
                                done <= 1'b1;
                            end else begin
                                err <= 1'b1;
                            end
                            cpu_hold <= 1'b0;
                            busy     <= 1'b0;
                            rx_ready <= 1'b0;
                            state    <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        rx_ready <= enable;
                        state    <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: a frame-level model queues expected RAM
// writes; a negedge monitor pops and compares each write strobe it sees.
module tb_prog_loader;

    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              enable = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic              mem_we;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;

    prog_loader #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_we   (mem_we),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int done_seen = 0;
    bit gaps = 1'b0;
    logic prev_we = 1'b0;

    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [7:0]        exp_data_q[$];
    logic [7:0]        payload[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: every write strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            prev_we = 1'b0;
        end else begin
            if (mem_we) begin
                chk("we_one_cycle", {31'd0, prev_we}, 32'd0);
                if (exp_addr_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_write: got addr %0h data %0h, required no write",
                             mem_addr, mem_data);
                end else begin
                    chk("wr_addr", {16'd0, mem_addr}, {16'd0, exp_addr_q.pop_front()});
                    chk("wr_data", {24'd0, mem_data}, {24'd0, exp_data_q.pop_front()});
                end
            end
            if (done) begin
                done_seen++;
                chk("done_err", {31'd0, err}, 32'd0);
            end
            prev_we = mem_we;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        if (gaps && $urandom_range(0, 3) == 0) begin
            rx_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < 64) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!rx_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL handshake_timeout: got rx_ready 0 for 64 cycles, required 1");
            return;
        end
        @(posedge clk);
        #1;
    endtask

    // Frame-level reference: checksum and write addresses come straight
    // from the frame rules, using the bytes in payload.
    task automatic send_frame(input logic [15:0] addr, input bit bad,
                              input int abort_after);
        int n;
        int d0;
        logic [7:0] s;
        logic [7:0] len;
        logic [7:0] csum;
        n   = payload.size();
        len = n[7:0];
        s   = addr[15:8] + addr[7:0] + len;
        for (int i = 0; i < n; i++) s = s + payload[i];
        csum = 8'h00 - s + {7'd0, bad};

        send_byte(8'hA5);
        chk("hdr_err_clear", {31'd0, err}, 32'd0);
        chk("hdr_hold", {31'd0, cpu_hold}, 32'd1);
        send_byte(addr[15:8]);
        send_byte(addr[7:0]);
        send_byte(len);
        for (int i = 0; i < n; i++) begin
            exp_addr_q.push_back(addr + 16'(i));
            exp_data_q.push_back(payload[i]);
            send_byte(payload[i]);
            if (i + 1 == abort_after) begin
                d0 = done_seen;
                enable   = 1'b0;
                rx_valid = 1'b0;
                @(posedge clk);
                #1;
                chk("abort_err", {31'd0, err}, 32'd1);
                chk("abort_hold", {31'd0, cpu_hold}, 32'd0);
                chk("abort_busy", {31'd0, busy}, 32'd0);
                repeat (2) @(posedge clk);
                #1;
                chk("abort_writes_left", exp_addr_q.size(), 32'd0);
                chk("abort_no_done", done_seen - d0, 32'd0);
                enable = 1'b1;
                @(posedge clk);
                #1;
                return;
            end
        end
        chk("hold_in_frame", {31'd0, cpu_hold}, 32'd1);
        d0 = done_seen;
        send_byte(csum);
        rx_valid = 1'b0;
        chk("done_hold_low", {31'd0, cpu_hold}, 32'd0);
        @(posedge clk);
        #1;
        chk("frame_err", {31'd0, err}, {31'd0, bad});
        chk("frame_done_cnt", done_seen - d0, bad ? 32'd0 : 32'd1);
        chk("frame_writes_left", exp_addr_q.size(), 32'd0);
        chk("frame_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_we"}, {31'd0, mem_we}, 32'd0);
        chk({tag, "_ready"}, {31'd0, rx_ready}, 32'd0);
        chk({tag, "_addr"}, {16'd0, mem_addr}, 32'd0);
        chk({tag, "_data"}, {24'd0, mem_data}, 32'd0);
        chk({tag, "_hold"}, {31'd0, cpu_hold}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", {31'd0, rx_ready}, 32'd1);

        payload = '{8'h11, 8'h22, 8'h33};
        send_frame(16'h0010, 1'b0, -1);

        payload = '{8'h11, 8'h22, 8'h33};
        send_frame(16'h0010, 1'b1, -1);
        send_byte(8'h00);
        rx_valid = 1'b0;
        chk("err_sticky", {31'd0, err}, 32'd1);

        send_byte(8'h00);
        send_byte(8'h7E);
        payload = '{8'h55};
        send_frame(16'h0020, 1'b0, -1);

        payload = {};
        for (int i = 0; i < 256; i++) payload.push_back(8'h01);
        send_frame(16'hFFFF, 1'b0, -1);

        payload = '{8'h11, 8'h22, 8'h33};
        send_frame(16'h0010, 1'b0, 2);

        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h40);
        send_byte(8'h02);
        send_byte(8'h5A);
        chk("pre_reset_we", {31'd0, mem_we}, 32'd1);
        rst      = 1'b0;
        rx_valid = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_midreset", {31'd0, rx_ready}, 32'd1);
        payload = '{8'h11, 8'h22, 8'h33};
        send_frame(16'h0010, 1'b0, -1);

        gaps = 1'b1;
        for (int f = 0; f < 25; f++) begin
            int n;
            int ab;
            logic [7:0] g;
            repeat ($urandom_range(0, 2)) begin
                g = 8'($urandom_range(0, 255));
                if (g == 8'hA5) g = 8'h00;
                send_byte(g);
            end
            n = $urandom_range(1, 12);
            payload = {};
            for (int i = 0; i < n; i++) payload.push_back(8'($urandom_range(0, 255)));
            ab = ($urandom_range(0, 7) == 0) ? $urandom_range(1, n) : -1;
            send_frame(16'($urandom_range(0, 65535)),
                       ($urandom_range(0, 3) == 0), ab);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
